// File: rtl/hilo_div_unit.sv
// Multi-cycle radix-2 restoring divider for DIV/DIVU.
// Results go to the HI/LO write path: hi = remainder, lo = quotient.
module hilo_div_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNTW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             annul,
    output logic             stall,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] quo_q, quo_d;    // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0] rem_q, rem_d;    // partial remainder
    logic [WIDTH-1:0] dvs_q, dvs_d;    // divisor magnitude
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    // Operand magnitudes, trial subtraction and sign fix-up.
    always_comb begin
        a_neg   = signed_div & a[WIDTH-1];
        b_neg   = signed_div & b[WIDTH-1];
        a_mag   = a_neg ? -a : a;
        b_mag   = b_neg ? -b : b;
        shifted = {rem_q, quo_q[WIDTH-1]};
        // rem_q < divisor keeps the true difference within WIDTH+1 bits, so the MSB is the sign.
        trial   = shifted - {1'b0, dvs_q};
        quo_fix = q_neg_q ? -quo_q : quo_q;
        rem_fix = r_neg_q ? -rem_q : rem_q;
    end

    // Next-state and output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvs_d   = dvs_q;
        q_neg_d = q_neg_q;
        r_neg_d = r_neg_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall   = 1'b0;
        ready   = 1'b0;
        hi      = hi_q;
        lo      = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start && !annul) begin
                    stall = 1'b1;
                    cnt_d = '0;
                    dvs_d = b_mag;
                    if (b == '0) begin
                        // Divide-by-zero: all-ones quotient, raw dividend as remainder, no fix-up.
                        quo_d   = '1;
                        rem_d   = a;
                        q_neg_d = 1'b0;
                        r_neg_d = 1'b0;
                        state_d = StDone;
                    end else begin
                        quo_d   = a_mag;
                        rem_d   = '0;
                        q_neg_d = a_neg ^ b_neg;
                        r_neg_d = a_neg;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                stall = 1'b1;
                if (annul) begin
                    state_d = StIdle;
                end else begin
                    quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
                    rem_d = trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
                    cnt_d = cnt_q + CNTW'(1);
                    if (cnt_q == CNTW'(WIDTH - 1)) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!annul) begin
                    ready = 1'b1;
                    hi    = rem_fix;
                    lo    = quo_fix;
                    hi_d  = rem_fix;
                    lo_d  = quo_fix;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            q_neg_q <= q_neg_d;
            r_neg_q <= r_neg_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed self-checking bench for hilo_div_unit (WIDTH = 32).
module tb_hilo_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic [31:0] a;
    logic [31:0] b;
    logic        annul;
    logic        stall;
    logic        ready;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_checks = 0;
    int n_errors = 0;

    hilo_div_unit #(
        .WIDTH(32),
        .CNTW (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_div(signed_div),
        .a         (a),
        .b         (b),
        .annul     (annul),
        .stall     (stall),
        .ready     (ready),
        .hi        (hi),
        .lo        (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Issue one op at cycle 0 and watch up to 60 cycles for ready; optionally pulse start
    // again in cycle extra (0 = never) to show it is ignored.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [31:0] op_b,
                          input logic sgn, input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                          input int exp_lat, input int extra);
        int          lat;
        int          stall_cnt;
        logic [31:0] got_lo;
        logic [31:0] got_hi;
        logic        stall_at_ready;
        lat            = -1;
        got_lo         = '0;
        got_hi         = '0;
        stall_at_ready = 1'b0;
        @(posedge clk);
        #1;
        start      = 1'b1;
        a          = op_a;
        b          = op_b;
        signed_div = sgn;
        @(negedge clk);
        stall_cnt = stall ? 1 : 0;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int k = 1; k <= 60 && lat < 0; k++) begin
            if (k == extra) start = 1'b1;
            @(negedge clk);
            if (ready) begin
                lat            = k;
                got_lo         = lo;
                got_hi         = hi;
                stall_at_ready = stall;
            end else if (stall) begin
                stall_cnt++;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        check_eq({tag, "_latency"}, lat, exp_lat);
        check_eq({tag, "_stall_cycles"}, stall_cnt, exp_lat);
        check_eq({tag, "_lo"}, got_lo, exp_lo);
        check_eq({tag, "_hi"}, got_hi, exp_hi);
        check_eq({tag, "_stall_at_ready"}, stall_at_ready, 1'b0);
        @(negedge clk);
        check_eq({tag, "_ready_pulse"}, ready, 1'b0);
    endtask

    initial begin
        int pulses;
        int stalls;
        rst        = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        a          = '0;
        b          = '0;
        annul      = 1'b0;

        // Reset state
        #12;
        check_eq("rst_stall", stall, 1'b0);
        check_eq("rst_ready", ready, 1'b0);
        check_eq("rst_hi", hi, 32'h0);
        check_eq("rst_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Arithmetic cases
        run_op("udiv_100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 0);
        run_op("sdiv_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 33, 0);
        run_op("sdiv_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 33, 0);
        run_op("udiv_by0", 32'h1234_5678, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h1234_5678, 1, 0);
        run_op("sdiv_by0", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1, 0);
        run_op("sdiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 33, 0);
        run_op("udiv_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000, 33, 0);

        // start with annul in IDLE is ignored
        @(posedge clk);
        #1;
        start = 1'b1;
        annul = 1'b1;
        a     = 32'd50;
        b     = 32'd5;
        @(negedge clk);
        check_eq("idle_annul_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0;
        annul = 1'b0;
        @(negedge clk);
        check_eq("idle_annul_no_busy", stall, 1'b0);

        // annul in BUSY cycle 10
        @(posedge clk);
        #1;
        start      = 1'b1;
        a          = 32'd1000;
        b          = 32'd3;
        signed_div = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        annul = 1'b1;
        @(negedge clk);
        check_eq("annul_ready", ready, 1'b0);
        @(posedge clk);
        #1;
        annul  = 1'b0;
        pulses = 0;
        stalls = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) pulses++;
            if (stall) stalls++;
        end
        check_eq("annul_no_ready", pulses, 0);
        check_eq("annul_idle", stalls, 0);
        check_eq("annul_hi_kept", hi, 32'h8000_0000);
        check_eq("annul_lo_kept", lo, 32'h0);

        // New op with an ignored start during BUSY
        run_op("udiv_9_3", 32'd9, 32'd3, 1'b0, 32'd3, 32'd0, 33, 5);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (ready) pulses++;
        end
        check_eq("busy_start_ignored", pulses, 0);

        // Asynchronous reset mid-BUSY
        @(posedge clk);
        #1;
        start = 1'b1;
        a     = 32'd77;
        b     = 32'd5;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_eq("arst_stall", stall, 1'b0);
        check_eq("arst_ready", ready, 1'b0);
        check_eq("arst_hi", hi, 32'h0);
        check_eq("arst_lo", lo, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        run_op("after_rst", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Multi-cycle integer divider for the execute stage; it services DIV/DIVU requests raised by the pipeline control path.
- Accepts a one-cycle start pulse with the operands and holds the pipeline via stall while iterating.
- Returns the quotient and remainder with a ready pulse, in the form the HI/LO write path consumes (HI = remainder, LO = quotient).
- Radix-2 restoring algorithm, one quotient bit per cycle.

Parameters:
- WIDTH, 32, operand width; quotient and remainder are each WIDTH bits.
- CNTW, 6, iteration counter width; must satisfy 2^CNTW > WIDTH.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- start  in  1  request a divide; sampled only in IDLE.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- annul  in  1  cancel the in-flight operation (pipeline flush or exception).
- stall  out  1  hold the pipeline.
- ready  out  1  one-cycle pulse; hi and lo are valid in this cycle.
- hi  out  WIDTH  remainder.
- lo  out  WIDTH  quotient.

Behaviour:
- Reset (rst low, asynchronous): state = IDLE, counter = 0, stall = 0, ready = 0, hi = 0, lo = 0. Reset asserted mid-operation aborts the operation immediately and no ready pulse is produced.
- States: IDLE, BUSY, DONE.
- IDLE:
  - When start=1 and annul=0:
    - latch the operand magnitudes (absolute values if signed_div=1, raw values otherwise);
    - latch the quotient sign (sign(a) XOR sign(b)) and the remainder sign (sign(a)), each only when signed_div=1;
    - clear the partial remainder; set counter = 0;
    - go to BUSY, or go to DONE if b == 0.
  - start=1 with annul=1 is ignored.
- BUSY:
  - Each cycle: shift the partial remainder left by one, bringing in the next dividend MSB.
  - Subtract the divisor magnitude in a WIDTH+1-bit trial.
  - If the trial result is non-negative, keep it and shift in quotient bit 1; otherwise shift in 0.
  - Increment counter. After iteration WIDTH (counter == WIDTH-1 at the edge), go to DONE.
- DONE:
  - Apply the sign fix-up: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Drive hi/lo with the fixed-up values and assert ready=1 for exactly this cycle, then return to IDLE.
  - hi/lo hold their values until the next DONE or reset.
- stall = (IDLE and start and not annul) or BUSY. stall is 0 in DONE, so the stage advances in the same cycle ready is high.
- Latency: start sampled at edge N; ready is high in cycle N+WIDTH+1 (33 cycles for WIDTH=32). Divide-by-zero: ready in cycle N+1.
- Divide-by-zero result: lo = all ones, hi = a (unsigned raw dividend), for both signed and unsigned. No exception is raised.
- Overflow: signed 0x80000000 / 0xFFFFFFFF gives lo = 0x80000000, hi = 0 (two's-complement wrap, no trap).
- annul:
  - In BUSY or DONE: go to IDLE on the next edge; ready is suppressed in that cycle; hi/lo are not updated.
  - annul has priority over start and over completion.
- start while BUSY or DONE is ignored; no queueing.
- Arithmetic: all internal arithmetic uses unsigned magnitudes; negation is two's-complement in WIDTH bits.

Test Plan:
- Unsigned: a=100, b=7, signed_div=0, start at cycle 0 → stall high in cycles 0–32; ready only in cycle 33; lo=14, hi=2.
- Signed: a=-7 (0xFFFFFFF9), b=2, signed_div=1 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also a=7, b=-2 → lo=0xFFFFFFFD, hi=1.
- Divide-by-zero: a=0x12345678, b=0 → ready in cycle 1; lo=0xFFFFFFFF, hi=0x12345678; stall high in cycle 0 only.
- Overflow: a=0x80000000, b=0xFFFFFFFF, signed → lo=0x80000000, hi=0. Unsigned with the same operands → lo=0, hi=0x80000000.
- annul asserted in BUSY cycle 10 → IDLE at the next edge; no ready pulse; hi/lo keep their previous values. A new start a=9, b=3 then yields lo=3, hi=0 after 33 cycles. A start pulse issued during BUSY of that op is ignored, so only one ready pulse occurs.
- rst driven low asynchronously mid-BUSY (between clock edges) → stall, ready, hi and lo are 0 immediately. After rst is released the unit is in IDLE and accepts a new start.
